remap_table_reader: RTL and testbench



---
 rtl/remap_table_reader.sv | 130 +++++++++++++
 tb/tb_remap_table_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/remap_table_reader.sv
// remap_table_reader: walks every remap table address, packs four entries per
// 32-bit word and streams the words out over a valid/ready handshake.
module remap_table_reader #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 7
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [31:0]       word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-2:0] word_count
);

   localparam int unsigned CNT_W  = ADDR_W - 1;
   localparam int unsigned LANE_W = 8;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t              state, state_n;
   logic [ADDR_W-1:0]   rd_addr_n;
   logic [WORD_W-1:0]   word_data_n;
   logic                word_valid_n;
   logic                busy_n;
   logic                done_n;
   logic [CNT_W-1:0]    word_count_n;
   logic [LANE_W-1:0]   entry;

   // Entry zero-extended to a full byte lane so upper lane bits stay 0.
   assign entry = LANE_W'(rd_data);

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         rd_addr    <= '0;
         word_data  <= '0;
         word_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         word_count <= '0;
      end else begin
         state      <= state_n;
         rd_addr    <= rd_addr_n;
         word_data  <= word_data_n;
         word_valid <= word_valid_n;
         busy       <= busy_n;
         done       <= done_n;
         word_count <= word_count_n;
      end
   end

   // Next-state and next-output logic; flags are derived from the next state
   // so word_valid/busy are registered and never follow word_ready combinationally.
   always_comb begin
      state_n      = state;
      rd_addr_n    = rd_addr;
      word_data_n  = word_data;
      done_n       = done;
      word_count_n = word_count;

      case (state)
         IDLE: begin
            if (start && !abort) begin
               rd_addr_n    = '0;
               word_count_n = '0;
               word_data_n  = '0;
               done_n       = 1'b0;
               state_n      = READ;
            end
         end

         READ: begin
            if (abort) begin
               rd_addr_n = '0;
               done_n    = 1'b0;
               state_n   = IDLE;
            end else begin
               case (rd_addr[1:0])
                  2'd0:    word_data_n[7:0]   = entry;
                  2'd1:    word_data_n[15:8]  = entry;
                  2'd2:    word_data_n[23:16] = entry;
                  default: word_data_n[31:24] = entry;
               endcase
               rd_addr_n = rd_addr + ADDR_W'(1);
               if (rd_addr[1:0] == 2'd3) begin
                  state_n = SEND;
               end
            end
         end

         SEND: begin
            if (abort) begin
               rd_addr_n = '0;
               done_n    = 1'b0;
               state_n   = IDLE;
            end else if (word_ready) begin
               word_count_n = word_count + CNT_W'(1);
               // rd_addr has wrapped to 0 once the final lane was captured.
               if (rd_addr == '0) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = READ;
               end
            end
         end

         default: begin
            rd_addr_n = '0;
            state_n   = IDLE;
         end
      endcase

      busy_n       = (state_n != IDLE);
      word_valid_n = (state_n == SEND);
   end

endmodule

// File: tb/tb_remap_table_reader.sv
// Directed testbench for remap_table_reader.
module tb_remap_table_reader;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [6:0]  rd_addr;
   logic [6:0]  rd_data;
   logic [31:0] word_data;
   logic        word_valid;
   logic        word_ready;
   logic        busy;
   logic        done;
   logic [5:0]  word_count;

   logic [6:0]  map_mem [128];
   logic [31:0] words [32];
   int          nw;
   int          done_cyc;
   logic        hold_ok;
   logic [6:0]  st_addr;
   logic [5:0]  st_cnt;
   logic [31:0] ored;

   int chk_cnt;
   int pass_cnt;

   remap_table_reader #(.ADDR_W(7), .DATA_W(7)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .busy       (busy),
      .done       (done),
      .word_count (word_count)
   );

   assign rd_data = map_mem[rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_word(input int k);
      exp_word = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
   endfunction

   task automatic fill_identity();
      for (int i = 0; i < 128; i++) map_mem[i] = 7'(i);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Runs a dump from the negedge after the start edge; cycle n = after edge n.
   task automatic collect(input int stall_word, input int stall_len, input int start_at);
      int   stall_left;
      logic held_set;
      logic [31:0] held;
      nw = 0; done_cyc = -1; hold_ok = 1'b1; held_set = 1'b0; held = '0;
      ored = '0; stall_left = stall_len; st_addr = '0; st_cnt = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         ored = ored | word_data;
         if (done && !busy) begin
            done_cyc = cyc;
            break;
         end
         start = (cyc == start_at);
         if (word_valid && nw == stall_word) begin
            if (!held_set) begin
               held = word_data;
               held_set = 1'b1;
            end else if (word_data !== held) begin
               hold_ok = 1'b0;
            end
         end
         if (word_valid && nw == stall_word && stall_left > 0) begin
            word_ready = 1'b0;
            stall_left--;
            st_addr = rd_addr;
            st_cnt = word_count;
         end else begin
            word_ready = 1'b1;
         end
         if (word_valid && word_ready) begin
            if (nw < 32) words[nw] = word_data;
            nw++;
         end
         @(negedge clk);
      end
      start = 1'b0;
      word_ready = 1'b1;
   endtask

   task automatic test_reset();
      int to;
      #2;
      chk_cnt++;
      if ({rd_addr, word_data, word_valid, busy, done, word_count} !== '0)
         $display("FAIL reset_initial: got addr=%h data=%h v=%b busy=%b done=%b cnt=%0d, required all 0",
                  rd_addr, word_data, word_valid, busy, done, word_count);
      else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
      fill_identity();
      word_ready = 1'b0;
      pulse_start();
      to = 0;
      while (!word_valid && to < 20) begin
         @(negedge clk);
         to++;
      end
      chk_cnt++;
      if (word_valid !== 1'b1) $display("FAIL reset_reach_send: word_valid=%b, required 1", word_valid);
      else pass_cnt++;
      #2 reset_n = 1'b0;
      #1;
      chk_cnt++;
      if ({rd_addr, word_data, word_valid, busy, done, word_count} !== '0)
         $display("FAIL reset_async: got addr=%h data=%h v=%b busy=%b done=%b cnt=%0d, required all 0",
                  rd_addr, word_data, word_valid, busy, done, word_count);
      else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
      word_ready = 1'b1;
      pulse_start();
      chk_cnt++;
      if (busy !== 1'b1) $display("FAIL reset_restart_busy: busy=%b, required 1", busy);
      else pass_cnt++;
      collect(-1, 0, -1);
      chk_cnt++;
      if (nw !== 32 || words[0] !== 32'h03020100)
         $display("FAIL reset_restart_dump: words=%0d first=%h, required 32 and 03020100", nw, words[0]);
      else pass_cnt++;
   endtask

   task automatic test_full_dump();
      fill_identity();
      word_ready = 1'b1;
      pulse_start();
      chk_cnt++;
      if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL full_start: busy=%b done=%b, required 1 0", busy, done);
      else pass_cnt++;
      collect(-1, 0, -1);
      chk_cnt++;
      if (nw !== 32) $display("FAIL full_count_words: got %0d, required 32", nw);
      else pass_cnt++;
      chk_cnt++;
      if (words[0] !== 32'h03020100) $display("FAIL full_word0: got %h, required 03020100", words[0]);
      else pass_cnt++;
      chk_cnt++;
      if (words[5] !== 32'h17161514) $display("FAIL full_word5: got %h, required 17161514", words[5]);
      else pass_cnt++;
      chk_cnt++;
      if (words[31] !== 32'h7F7E7D7C) $display("FAIL full_word31: got %h, required 7F7E7D7C", words[31]);
      else pass_cnt++;
      for (int k = 0; k < 32; k++) begin
         chk_cnt++;
         if (words[k] !== exp_word(k)) $display("FAIL full_word_%0d: got %h, required %h", k, words[k], exp_word(k));
         else pass_cnt++;
      end
      chk_cnt++;
      if (done_cyc !== 160) $display("FAIL full_done_cycle: got %0d, required 160", done_cyc);
      else pass_cnt++;
      chk_cnt++;
      if (word_count !== 6'd32 || busy !== 1'b0 || word_valid !== 1'b0)
         $display("FAIL full_end_state: cnt=%0d busy=%b v=%b, required 32 0 0", word_count, busy, word_valid);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      fill_identity();
      pulse_start();
      collect(5, 10, -1);
      chk_cnt++;
      if (hold_ok !== 1'b1) $display("FAIL bp_hold_data: word_data changed while stalled, required held");
      else pass_cnt++;
      chk_cnt++;
      if (st_addr !== 7'h18) $display("FAIL bp_rd_addr: got %h, required 18", st_addr);
      else pass_cnt++;
      chk_cnt++;
      if (st_cnt !== 6'd5) $display("FAIL bp_word_count: got %0d, required 5", st_cnt);
      else pass_cnt++;
      chk_cnt++;
      if (words[5] !== 32'h17161514) $display("FAIL bp_word5: got %h, required 17161514", words[5]);
      else pass_cnt++;
      chk_cnt++;
      if (nw !== 32 || words[31] !== 32'h7F7E7D7C)
         $display("FAIL bp_complete: words=%0d last=%h, required 32 7F7E7D7C", nw, words[31]);
      else pass_cnt++;
      chk_cnt++;
      if (done_cyc !== 170) $display("FAIL bp_done_cycle: got %0d, required 170", done_cyc);
      else pass_cnt++;
   endtask

   task automatic test_abort();
      int hs;
      logic found;
      fill_identity();
      word_ready = 1'b1;
      pulse_start();
      hs = 0;
      found = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (hs == 10 && busy && !word_valid) begin
            found = 1'b1;
            break;
         end
         if (word_valid && word_ready) hs++;
         @(negedge clk);
      end
      chk_cnt++;
      if (found !== 1'b1 || rd_addr !== 7'd40)
         $display("FAIL abort_reach_word10: found=%b addr=%0d, required 1 40", found, rd_addr);
      else pass_cnt++;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_cnt++;
      if ({busy, word_valid, done} !== 3'b000 || rd_addr !== 7'd0)
         $display("FAIL abort_idle: busy=%b v=%b done=%b addr=%h, required 0 0 0 00", busy, word_valid, done, rd_addr);
      else pass_cnt++;
      chk_cnt++;
      if (word_count !== 6'd10) $display("FAIL abort_partial_count: got %0d, required 10", word_count);
      else pass_cnt++;
      pulse_start();
      collect(-1, 0, -1);
      chk_cnt++;
      if (nw !== 32 || words[0] !== 32'h03020100 || words[10] !== 32'h2B2A2928 || words[31] !== 32'h7F7E7D7C)
         $display("FAIL abort_redump: words=%0d w0=%h w10=%h w31=%h, required 32 03020100 2B2A2928 7F7E7D7C",
                  nw, words[0], words[10], words[31]);
      else pass_cnt++;
   endtask

   task automatic test_control();
      int bad;
      fill_identity();
      pulse_start();
      collect(-1, 0, 50);
      bad = 0;
      for (int k = 0; k < 32; k++) if (words[k] !== exp_word(k)) bad++;
      chk_cnt++;
      if (nw !== 32 || bad !== 0 || done_cyc !== 160)
         $display("FAIL ctl_start_while_busy: words=%0d bad=%0d done_cyc=%0d, required 32 0 160", nw, bad, done_cyc);
      else pass_cnt++;
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk_cnt++;
      if (busy !== 1'b0 || done !== 1'b1 || rd_addr !== 7'd0)
         $display("FAIL ctl_start_abort: busy=%b done=%b addr=%h, required 0 1 00", busy, done, rd_addr);
      else pass_cnt++;
      pulse_start();
      chk_cnt++;
      if (done !== 1'b0 || busy !== 1'b1 || word_count !== 6'd0)
         $display("FAIL ctl_start_after_done: done=%b busy=%b cnt=%0d, required 0 1 0", done, busy, word_count);
      else pass_cnt++;
      collect(-1, 0, -1);
      chk_cnt++;
      if (nw !== 32 || done !== 1'b1) $display("FAIL ctl_redump: words=%0d done=%b, required 32 1", nw, done);
      else pass_cnt++;
   endtask

   task automatic test_zero_ext();
      int bad;
      for (int i = 0; i < 128; i++) map_mem[i] = 7'h7F;
      pulse_start();
      collect(-1, 0, -1);
      bad = 0;
      for (int k = 0; k < 32; k++) if (words[k] !== 32'h7F7F7F7F) bad++;
      chk_cnt++;
      if (nw !== 32 || bad !== 0)
         $display("FAIL zext_words: words=%0d bad=%0d, required 32 0", nw, bad);
      else pass_cnt++;
      chk_cnt++;
      if ((ored & 32'h80808080) !== 32'h0)
         $display("FAIL zext_bit7: observed OR=%h, required lane bit 7 never set", ored);
      else pass_cnt++;
   endtask

   initial begin
      chk_cnt = 0;
      pass_cnt = 0;
      reset_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      word_ready = 1'b1;
      for (int i = 0; i < 128; i++) map_mem[i] = 7'(i);
      test_reset();
      test_full_dump();
      test_backpressure();
      test_abort();
      test_control();
      test_zero_ext();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
